// File: rtl/hazard_ctrl_p.sv
// Hazard and forwarding controller for the five-stage pipeline:
// EX bypass selects, load-use stall sequencing, redirect flush, event counters.
module hazard_ctrl_p #(
  parameter int NUM_RS   = 2,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     de_valid,
  input  logic [NUM_RS*REG_AW-1:0] de_rs,
  input  logic                     ex_valid,
  input  logic [NUM_RS*REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0]        ex_rd,
  input  logic                     ex_we,
  input  logic                     ex_is_load,
  input  logic [REG_AW-1:0]        mem_rd,
  input  logic                     mem_we,
  input  logic                     mem_is_load,
  input  logic [REG_AW-1:0]        wb_rd,
  input  logic                     wb_we,
  input  logic                     redirect,
  output logic [2*NUM_RS-1:0]      fwd_sel,
  output logic                     stall_fe,
  output logic                     stall_de,
  output logic                     bubble_ex,
  output logic                     flush_de,
  output logic                     flush_ex,
  output logic [CNT_W-1:0]         stall_events,
  output logic [CNT_W-1:0]         flush_events
);

  typedef enum logic {
    IDLE,
    STALL
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);
  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  state_t     state;
  logic [2:0] cnt;
  logic       hit;
  logic       stall_c;
  logic       flush_c;
  logic       ld_ex;
  logic       mem_fwd_ok;

  assign mem_fwd_ok = mem_we && !mem_is_load;

  // MEM is younger than WB, so its result wins
  for (genvar i = 0; i < NUM_RS; i++) begin : g_fwd
    logic [REG_AW-1:0] rs;
    assign rs = ex_rs[i*REG_AW +: REG_AW];
    always_comb begin
      fwd_sel[2*i +: 2] = SEL_RF;
      if (rs == '0)
        fwd_sel[2*i +: 2] = SEL_RF;
      else if (mem_fwd_ok && mem_rd == rs)
        fwd_sel[2*i +: 2] = SEL_MEM;
      else if (wb_we && wb_rd == rs)
        fwd_sel[2*i +: 2] = SEL_WB;
    end
  end

  assign ld_ex = ex_valid && ex_is_load && ex_we && (ex_rd != '0);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_RS; i++)
      if (de_rs[i*REG_AW +: REG_AW] == ex_rd)
        hit = 1'b1;
    hit = hit && ld_ex && de_valid;
  end

  always_comb begin
    stall_c = 1'b0;
    unique case (state)
      IDLE:  stall_c = hit;
      STALL: stall_c = 1'b1;
      default: stall_c = 1'b0;
    endcase
    stall_c = stall_c && !redirect && reset;
  end

  assign flush_c   = redirect && reset;
  assign stall_fe  = stall_c;
  assign stall_de  = stall_c;
  assign bubble_ex = stall_c;
  assign flush_de  = flush_c;
  assign flush_ex  = flush_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (redirect) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit && LOAD_LAT > 1) begin
            state <= STALL;
            cnt   <= LAT_M1;
          end
        end
        STALL: begin
          if (cnt <= 3'd1) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_events <= '0;
      flush_events <= '0;
    end else begin
      if (stall_c && stall_events != '1)
        stall_events <= stall_events + 1'b1;
      if (flush_c && flush_events != '1)
        flush_events <= flush_events + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_p.sv
// Directed bench for hazard_ctrl_p: vector table for the
// combinational paths, hand sequences for stall/flush timing.
module tb_hazard_ctrl_p;

  logic        clk = 1'b0;
  logic        reset;
  logic        de_valid;
  logic [9:0]  de_rs;
  logic        ex_valid;
  logic [9:0]  ex_rs;
  logic [4:0]  ex_rd;
  logic        ex_we;
  logic        ex_is_load;
  logic [4:0]  mem_rd;
  logic        mem_we;
  logic        mem_is_load;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic        redirect;

  logic [3:0]  fwd3, fwd1;
  logic        sfe3, sde3, bub3, fde3, fex3;
  logic        sfe1, sde1, bub1, fde1, fex1;
  logic [3:0]  se3, fe3;
  logic [15:0] se1, fe1;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  hazard_ctrl_p #(.NUM_RS(2), .REG_AW(5), .LOAD_LAT(3), .CNT_W(4)) u_l3 (
    .clk(clk), .reset(reset),
    .de_valid(de_valid), .de_rs(de_rs),
    .ex_valid(ex_valid), .ex_rs(ex_rs),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_is_load(mem_is_load),
    .wb_rd(wb_rd), .wb_we(wb_we), .redirect(redirect),
    .fwd_sel(fwd3), .stall_fe(sfe3), .stall_de(sde3),
    .bubble_ex(bub3), .flush_de(fde3), .flush_ex(fex3),
    .stall_events(se3), .flush_events(fe3)
  );

  hazard_ctrl_p #(.NUM_RS(2), .REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u_l1 (
    .clk(clk), .reset(reset),
    .de_valid(de_valid), .de_rs(de_rs),
    .ex_valid(ex_valid), .ex_rs(ex_rs),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_is_load(mem_is_load),
    .wb_rd(wb_rd), .wb_we(wb_we), .redirect(redirect),
    .fwd_sel(fwd1), .stall_fe(sfe1), .stall_de(sde1),
    .bubble_ex(bub1), .flush_de(fde1), .flush_ex(fex1),
    .stall_events(se1), .flush_events(fe1)
  );

  typedef struct {
    int rs0, rs1, mrd, mwe, mld, wrd, wwe;
    int dv, drs0, drs1, ev, erd, ewe, eld, rdr;
    int efwd, est, efl;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr();
    de_valid = 0; de_rs = '0; ex_valid = 0; ex_rs = '0;
    ex_rd = '0; ex_we = 0; ex_is_load = 0;
    mem_rd = '0; mem_we = 0; mem_is_load = 0;
    wb_rd = '0; wb_we = 0; redirect = 0;
  endtask

  task automatic set_hit();
    de_valid = 1; de_rs = {5'd7, 5'd0};
    ex_valid = 1; ex_rd = 5'd7; ex_we = 1; ex_is_load = 1;
  endtask

  task automatic rst_hold();
    clr();
    reset = 0;
    @(posedge clk);
    #2;
  endtask

  task automatic apply(input vec_t v);
    ex_rs       = {5'(v.rs1), 5'(v.rs0)};
    mem_rd      = 5'(v.mrd);
    mem_we      = 1'(v.mwe);
    mem_is_load = 1'(v.mld);
    wb_rd       = 5'(v.wrd);
    wb_we       = 1'(v.wwe);
    de_valid    = 1'(v.dv);
    de_rs       = {5'(v.drs1), 5'(v.drs0)};
    ex_valid    = 1'(v.ev);
    ex_rd       = 5'(v.erd);
    ex_we       = 1'(v.ewe);
    ex_is_load  = 1'(v.eld);
    redirect    = 1'(v.rdr);
  endtask

  initial begin
    // rs0 rs1 mrd mwe mld wrd wwe | dv drs0 drs1 ev erd ewe eld rdr | fwd st fl
    vt.push_back('{5, 0, 5, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0});
    vt.push_back('{5, 0, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0});
    vt.push_back('{0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vt.push_back('{5, 0, 5, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0});
    vt.push_back('{3, 9, 9, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0});
    vt.push_back('{3, 9, 9, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 0, 7, 1, 7, 1, 1, 0, 0, 1, 0});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 1, 7, 1, 1, 0, 0, 0, 0});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 0, 7, 1, 7, 1, 0, 0, 0, 0, 0});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 0, 7, 1, 7, 1, 1, 1, 0, 0, 1});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 0, 7, 1, 7, 0, 1, 0, 0, 0, 0});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 7, 3, 1, 7, 1, 1, 0, 0, 1, 0});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 7, 3, 0, 7, 1, 1, 0, 0, 0, 0});
    vt.push_back('{7, 0, 7, 1, 0, 0, 0, 1, 0, 7, 1, 7, 1, 1, 0, 1, 1, 0});

    rst_hold();
    set_hit();
    redirect = 1;
    #1;
    chk("rst_stall3", {sfe3, sde3, bub3}, 0);
    chk("rst_flush3", {fde3, fex3}, 0);
    chk("rst_cnt3", {se3, fe3}, 0);
    chk("rst_cnt1", {se1, fe1}, 0);

    foreach (vt[k]) begin
      @(negedge clk);
      apply(vt[k]);
      reset = 1;
      #2;
      chk($sformatf("v%0d_fwd3", k), fwd3, 32'(vt[k].efwd));
      chk($sformatf("v%0d_fwd1", k), fwd1, 32'(vt[k].efwd));
      chk($sformatf("v%0d_st3", k), {sfe3, sde3, bub3},
          vt[k].est != 0 ? 32'd7 : 32'd0);
      chk($sformatf("v%0d_st1", k), {sfe1, sde1, bub1},
          vt[k].est != 0 ? 32'd7 : 32'd0);
      chk($sformatf("v%0d_fl", k), {fde3, fex3, fde1, fex1},
          vt[k].efl != 0 ? 32'd15 : 32'd0);
      reset = 0;
    end

    // load-use: LOAD_LAT 3 vs 1
    rst_hold();
    @(negedge clk); reset = 1; set_hit(); #2;
    chk("lu_c0_st3", sfe3, 1);
    chk("lu_c0_st1", sfe1, 1);
    @(negedge clk); ex_valid = 0; #2;
    chk("lu_c1_st3", {sfe3, sde3, bub3}, 7);
    chk("lu_c1_st1", sfe1, 0);
    chk("lu_c1_se1", se1, 1);
    @(negedge clk); #2;
    chk("lu_c2_st3", sfe3, 1);
    @(negedge clk); #2;
    chk("lu_c3_st3", sfe3, 0);
    chk("lu_c3_se3", se3, 3);
    chk("lu_c3_se1", se1, 1);

    // redirect during STALL, then hit coincident with redirect
    rst_hold();
    @(negedge clk); reset = 1; set_hit(); #2;
    chk("rd_c0_st3", sfe3, 1);
    @(negedge clk); ex_valid = 0; redirect = 1; #2;
    chk("rd_c1_st3", {sfe3, sde3, bub3}, 0);
    chk("rd_c1_fl3", {fde3, fex3}, 3);
    @(negedge clk); redirect = 0; #2;
    chk("rd_c2_st3", sfe3, 0);
    chk("rd_c2_fe3", fe3, 1);
    chk("rd_c2_se3", se3, 1);
    @(negedge clk); set_hit(); redirect = 1; #2;
    chk("rdh_st3", sfe3, 0);
    chk("rdh_st1", sfe1, 0);
    @(negedge clk); clr(); #2;
    chk("rdh_st3_after", sfe3, 0);
    chk("rdh_se3", se3, 1);
    chk("rdh_fe3", fe3, 2);
    chk("rdh_fe1", fe1, 2);

    // counter saturation
    rst_hold();
    @(negedge clk); reset = 1; redirect = 1;
    repeat (20) @(negedge clk);
    redirect = 0; #2;
    chk("sat_fe3", fe3, 15);
    chk("sat_fe1", fe1, 20);
    chk("sat_se3", se3, 0);

    // async reset mid-stall
    rst_hold();
    @(negedge clk); reset = 1; set_hit(); #2;
    chk("ar_c0_st3", sfe3, 1);
    @(negedge clk); ex_valid = 0; #2;
    chk("ar_c1_st3", sfe3, 1);
    #1; reset = 0;
    ex_rs = {5'd0, 5'd5}; mem_rd = 5'd5; mem_we = 1;
    #1;
    chk("ar_rst_st3", {sfe3, sde3, bub3}, 0);
    chk("ar_rst_cnt3", {se3, fe3}, 0);
    chk("ar_rst_se1", se1, 0);
    chk("ar_rst_fwd3", fwd3, 1);
    @(negedge clk); clr(); reset = 1; #2;
    chk("ar_rel_st3", sfe3, 0);
    @(negedge clk); set_hit(); #2;
    chk("ar_h0_st3", sfe3, 1);
    @(negedge clk); ex_valid = 0; #2;
    chk("ar_h1_st3", sfe3, 1);
    @(negedge clk); #2;
    chk("ar_h2_st3", sfe3, 1);
    @(negedge clk); #2;
    chk("ar_h3_st3", sfe3, 0);
    chk("ar_h3_se3", se3, 3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_p.md
# hazard_ctrl_p

Parametrised hazard and forwarding controller for the five-stage RISC-V pipeline. It replaces the per-operand forwarding units with one block that covers `NUM_RS` source operands. It adds load-use stall detection with a configurable load latency, branch-redirect flush control, and saturating stall/flush event counters. It sits beside the pipeline top: it reads the register addresses and write enables of DE/EX/MEM/WB, drives the EX bypass selects, and drives the fetch/decode hold and bubble/flush controls.

## Interface
Parameters:
- `NUM_RS`, 2: source operands checked per instruction (1..3).
- `REG_AW`, 5: register address width.
- `LOAD_LAT`, 1: stall cycles inserted on a load-use hazard (1..7).
- `CNT_W`, 16: event counter width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `de_valid`  in  1  decode stage holds a real instruction.
- `de_rs`  in  NUM_RS*REG_AW  decode-stage sources, port i at bits [i*REG_AW +: REG_AW].
- `ex_valid`  in  1  EX holds a real instruction.
- `ex_rs`  in  NUM_RS*REG_AW  EX-stage sources, same packing as `de_rs`.
- `ex_rd`, `ex_we`, `ex_is_load`  in  REG_AW/1/1  EX destination, write enable, and load flag.
- `mem_rd`, `mem_we`, `mem_is_load`  in  REG_AW/1/1  MEM destination, write enable, and load flag.
- `wb_rd`, `wb_we`  in  REG_AW/1  WB destination and write enable.
- `redirect`  in  1  branch/jump taken, resolved in EX this cycle.
- `fwd_sel`  out  2*NUM_RS  per-port bypass select: 00 register file, 01 MEM ALU result, 10 WB data.
- `stall_fe`, `stall_de`  out  1  hold the PC and the fetch/decode register.
- `bubble_ex`  out  1  load a NOP into the decode/execute register.
- `flush_de`, `flush_ex`  out  1  squash the fetch/decode and decode/execute registers.
- `stall_events`, `flush_events`  out  CNT_W  saturating counters.

## Operation
- **Forwarding (combinational), per port i, with rs = ex_rs[i]:**
  - rs==0 → 00.
  - Otherwise, if mem_we && !mem_is_load && mem_rd==rs → 01.
  - Otherwise, if wb_we && wb_rd==rs → 10.
  - Otherwise → 00.
  - MEM has priority over WB (younger result wins).
- **Load-use detect:** `hit` = ex_valid && ex_is_load && ex_we && ex_rd!=0 && de_valid && (any port i: de_rs[i]==ex_rd).
- **FSM:** states IDLE and STALL, plus a 3-bit `cnt`.
  - IDLE, hit && !redirect: assert stalls this cycle. If LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1; otherwise stay in IDLE.
  - STALL: assert stalls and decrement cnt. When cnt reaches 1, return to IDLE on the following edge. `hit` is ignored in STALL.
- **Stall outputs:** `stall_fe` = `stall_de` = `bubble_ex` = (IDLE && hit && !redirect) || (STALL && !redirect).
- **Redirect:**
  - `flush_de` = `flush_ex` = `redirect`.
  - Redirect overrides everything: stall outputs are forced to 0 and the FSM goes to IDLE with cnt=0 on the next edge.
- **Counters:**
  - `stall_events` +1 on every cycle with `stall_fe`=1.
  - `flush_events` +1 on every cycle with `redirect`=1.
  - Both saturate at 2^CNT_W-1 and never wrap.

## Timing
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE, cnt=0, both counters 0.
  - All stall/flush outputs are forced to 0 while reset is low, regardless of inputs.
  - `fwd_sel` stays combinational and valid throughout.
- `fwd_sel`, `flush_*`, and stall outputs on hit have 0-cycle latency (same cycle as inputs).
- A load-use hit at cycle N gives stall outputs high in cycles N..N+LOAD_LAT-1 exactly, low at N+LOAD_LAT unless a new hit occurs.
- Counters update on the edge ending the counted cycle; values are visible the next cycle.
- Reset deasserted mid-stall: the FSM restarts from IDLE; no residual stall cycles.
- A hit coincident with redirect produces no stall, no count; the flush is counted.

## Test plan
- **Forward priority:** ex_rs0=5, mem_we=1/mem_rd=5, wb_we=1/wb_rd=5 → fwd_sel[1:0]=01. Then mem_we=0 → 10. Then ex_rs0=0 with all matches → 00.
- **Load-use, LOAD_LAT=1:** load to x7 in EX, de_rs1=7 at cycle 10 → stall_fe/stall_de/bubble_ex high in cycle 10 only; stall_events=1 at cycle 11.
- **Load-use, LOAD_LAT=3:** same stimulus → stalls high in cycles 10,11,12, low at 13; stall_events=3.
- **Redirect:** redirect during STALL at cycle 11 (LOAD_LAT=3) → flush_de/flush_ex=1 and stalls 0 in cycle 11, IDLE at 12; flush_events=1. Hit with redirect in the same cycle → no stall.
- **Saturation:** CNT_W=4, 20 consecutive redirect cycles → flush_events holds at 15.
- **Async reset:** reset low at mid-cycle during STALL → stalls drop immediately, counters read 0, first hit after release behaves as in the load-use scenarios.
